// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O responder: register offsets,
// STATUS bit positions, write-size encodings and FSM states.
package io_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_SCRATCH = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_UNF   = 5;
  localparam int unsigned ST_TX_CNT   = 8;
  localparam int unsigned ST_RX_CNT   = 16;
  localparam int unsigned ST_CNT_W    = 8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Wait-latency counter width (LATENCY range 0-15)
  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: push/push_data write side, pop read side, head = oldest entry,
// full/empty flags and occupancy count. Push while full is accepted only
// when a pop happens in the same cycle; pop while empty is ignored.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bus_io_responder.sv
// Memory-mapped I/O slave on the shared system bus.
// Ports: clk/reset; bus side en, rd_wr, addr, wr_size, data (tristate),
// ready strobe; device TX side dev_tx_valid/ready/data; device RX side
// dev_rx_valid/ready/data; irq level interrupt.
// Each access is answered with a one-cycle ready LATENCY+1 cycles after en.
module bus_io_responder
  import io_pkg::*;
#(
  parameter int unsigned DATAW      = 32,
  parameter int unsigned ADDRW      = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rd_wr,
  input  logic [ADDRW-1:0] addr,
  input  logic [1:0]       wr_size,
  inout  wire  [DATAW-1:0] data,
  output logic             ready,
  output logic             dev_tx_valid,
  input  logic             dev_tx_ready,
  output logic [DATAW-1:0] dev_tx_data,
  input  logic             dev_rx_valid,
  output logic             dev_rx_ready,
  input  logic [DATAW-1:0] dev_rx_data,
  output logic             irq
);

  localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t           state, state_next;
  logic [LAT_W-1:0] cnt, cnt_next;

  logic [1:0]       lat_reg;
  logic             lat_wr;
  logic [1:0]       lat_size;
  logic [DATAW-1:0] lat_data;

  logic [DATAW-1:0] scratch;
  logic             tx_ovf, rx_unf;

  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [FC_W-1:0]  tx_count, rx_count;
  logic [DATAW-1:0] rx_head;

  logic             acc_rd, acc_wr;
  logic             tx_push, tx_ovf_set;
  logic             rx_pop, rx_unf_set;
  logic             status_clr;
  logic [DATAW-1:0] status;
  logic [DATAW-1:0] rdata;

  logic             addr_unused;
  assign addr_unused = ^{addr[ADDRW-1:4], addr[1:0]};

  // State, wait counter and registered ready strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= (state_next == S_RESP);
    end
  end

  // Next-state logic; DONE blocks a held en from starting a second access
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (en) begin
          if (LATENCY == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!en)             state_next = S_IDLE;
        else if (cnt == '0)  state_next = S_RESP;
        else                 cnt_next   = cnt - LAT_W'(1);
      end
      S_RESP:  state_next = S_DONE;
      S_DONE:  if (!en) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the access when it is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_reg  <= '0;
      lat_wr   <= 1'b0;
      lat_size <= '0;
      lat_data <= '0;
    end else if (state == S_IDLE && en) begin
      lat_reg  <= addr[3:2];
      lat_wr   <= rd_wr;
      lat_size <= wr_size;
      lat_data <= data;
    end
  end

  // Side-effect strobes, all confined to the RESP cycle
  always_comb begin
    acc_rd     = (state == S_RESP) && !lat_wr;
    acc_wr     = (state == S_RESP) && lat_wr;
    tx_push    = acc_wr && (lat_reg == REG_DATA);
    // A simultaneous device pop frees a slot, so no overflow then
    tx_ovf_set = tx_push && tx_full && !dev_tx_ready;
    rx_pop     = acc_rd && (lat_reg == REG_DATA) && !rx_empty;
    rx_unf_set = acc_rd && (lat_reg == REG_DATA) && rx_empty;
    status_clr = acc_rd && (lat_reg == REG_STATUS);
  end

  // STATUS snapshot and read mux
  always_comb begin
    status                        = '0;
    status[ST_TX_FULL]            = tx_full;
    status[ST_TX_EMPTY]           = tx_empty;
    status[ST_RX_EMPTY]           = rx_empty;
    status[ST_RX_FULL]            = rx_full;
    status[ST_TX_OVF]             = tx_ovf;
    status[ST_RX_UNF]             = rx_unf;
    status[ST_TX_CNT +: ST_CNT_W] = ST_CNT_W'(tx_count);
    status[ST_RX_CNT +: ST_CNT_W] = ST_CNT_W'(rx_count);
    rdata = '0;
    case (lat_reg)
      REG_DATA:    rdata = rx_empty ? '0 : rx_head;
      REG_STATUS:  rdata = status;
      REG_SCRATCH: rdata = scratch;
      default:     rdata = '0;
    endcase
  end

  // Sticky error bits and scratch register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf  <= 1'b0;
      rx_unf  <= 1'b0;
      scratch <= '0;
    end else begin
      tx_ovf <= (tx_ovf & ~status_clr) | tx_ovf_set;
      rx_unf <= (rx_unf & ~status_clr) | rx_unf_set;
      if (acc_wr && lat_reg == REG_SCRATCH) begin
        case (lat_size)
          SIZE_BYTE: scratch[7:0]  <= lat_data[7:0];
          SIZE_HALF: scratch[15:0] <= lat_data[15:0];
          default:   scratch       <= lat_data;
        endcase
      end
    end
  end

  io_sync_fifo #(.WIDTH(DATAW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (lat_data),
    .pop       (dev_tx_ready),
    .head      (dev_tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  io_sync_fifo #(.WIDTH(DATAW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dev_rx_valid),
    .push_data (dev_rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign dev_tx_valid = ~tx_empty;
  assign dev_rx_ready = ~rx_full;
  assign irq          = ~rx_empty | tx_ovf | rx_unf;
  assign data         = acc_rd ? rdata : 'z;

endmodule

// File: tb/tb_bus_io_responder.sv
// Directed self-checking bench for bus_io_responder (LATENCY = 2, depth 8).
module tb_bus_io_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        rd_wr;
  logic [31:0] addr;
  logic [1:0]  wr_size;
  wire  [31:0] data;
  logic        ready;
  logic        dev_tx_valid;
  logic        dev_tx_ready;
  logic [31:0] dev_tx_data;
  logic        dev_rx_valid;
  logic        dev_rx_ready;
  logic [31:0] dev_rx_data;
  logic        irq;

  logic        tb_oe;
  logic [31:0] tb_data;

  int total = 0;
  int bad   = 0;

  assign data = tb_oe ? tb_data : 'z;

  always #5 clk = ~clk;

  bus_io_responder #(.DATAW(32), .ADDRW(32), .FIFO_DEPTH(8), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rd_wr        (rd_wr),
    .addr         (addr),
    .wr_size      (wr_size),
    .data         (data),
    .ready        (ready),
    .dev_tx_valid (dev_tx_valid),
    .dev_tx_ready (dev_tx_ready),
    .dev_tx_data  (dev_tx_data),
    .dev_rx_valid (dev_rx_valid),
    .dev_rx_ready (dev_rx_ready),
    .dev_rx_data  (dev_rx_data),
    .irq          (irq)
  );

  typedef struct {
    bit          wr;
    logic [1:0]  off;
    logic [1:0]  size;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Released bus: Z in four-state simulators, zero where Z collapses to 0
  function automatic bit bus_released();
    return $isunknown(data) || (data == 32'h0);
  endfunction

  // One complete bus access; checks latency, pulse width and bus release
  task automatic bus_access(input bit wr, input logic [1:0] off, input logic [1:0] size,
                            input logic [31:0] wd, output logic [31:0] rd);
    int lat;
    bit seen;
    bit zbad;
    @(negedge clk);
    en = 1'b1; rd_wr = wr; addr = {28'h0, off, 2'b00}; wr_size = size;
    tb_oe = wr; tb_data = wd;
    seen = 1'b0; zbad = 1'b0; lat = 0; rd = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ready) begin
        seen = 1'b1;
        rd = data;
      end else if (!wr && !bus_released()) begin
        zbad = 1'b1;
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'd3);
    @(posedge clk); #1;
    check("ready_width", 32'(ready), 32'd0);
    if (!wr && !bus_released()) zbad = 1'b1;
    @(negedge clk);
    en = 1'b0; tb_oe = 1'b0;
    if (!wr) check("bus_release", 32'(zbad), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          rcnt;

    reset = 1'b1; en = 1'b0; rd_wr = 1'b0; addr = '0; wr_size = 2'd2;
    tb_oe = 1'b0; tb_data = '0;
    dev_tx_ready = 1'b0; dev_rx_valid = 1'b0; dev_rx_data = '0;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_bus", 32'(bus_released()), 32'd1);
    check("rst_tx_valid", 32'(dev_tx_valid), 32'd0);
    check("rst_rx_ready", 32'(dev_rx_ready), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Register-map vectors: {wr, offset, size, write data, expected read}
    vecs[0]  = '{1'b0, 2'd1, 2'd2, 32'h0,         32'h0000_0006};
    vecs[1]  = '{1'b0, 2'd2, 2'd2, 32'h0,         32'h0000_0000};
    vecs[2]  = '{1'b1, 2'd0, 2'd2, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 2'd2, 32'h0,         32'h0000_0104};
    vecs[4]  = '{1'b1, 2'd2, 2'd2, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b1, 2'd2, 2'd0, 32'h5566_77AB, 32'h0};
    vecs[6]  = '{1'b0, 2'd2, 2'd2, 32'h0,         32'hFFFF_FFAB};
    vecs[7]  = '{1'b1, 2'd2, 2'd1, 32'h9999_1234, 32'h0};
    vecs[8]  = '{1'b0, 2'd2, 2'd2, 32'h0,         32'hFFFF_1234};
    vecs[9]  = '{1'b1, 2'd2, 2'd3, 32'hDEAD_BEEF, 32'h0};
    vecs[10] = '{1'b0, 2'd2, 2'd2, 32'h0,         32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 2'd3, 2'd2, 32'h0,         32'h0000_0000};
    vecs[12] = '{1'b1, 2'd3, 2'd2, 32'h0000_0055, 32'h0};
    vecs[13] = '{1'b1, 2'd1, 2'd2, 32'hFFFF_FFFF, 32'h0};
    vecs[14] = '{1'b0, 2'd1, 2'd2, 32'h0,         32'h0000_0104};
    vecs[15] = '{1'b0, 2'd2, 2'd2, 32'h0,         32'hDEAD_BEEF};

    for (int i = 0; i < 16; i++) begin
      bus_access(vecs[i].wr, vecs[i].off, vecs[i].size, vecs[i].wd, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // TX head is the first DATA write; device drains it
    @(negedge clk);
    check("tx_valid_1", 32'(dev_tx_valid), 32'd1);
    check("tx_head_1", dev_tx_data, 32'h1122_3344);
    dev_tx_ready = 1'b1;
    @(negedge clk);
    dev_tx_ready = 1'b0;
    check("tx_drained", 32'(dev_tx_valid), 32'd0);

    // Nine DATA writes into an 8-deep FIFO: last one overflows
    for (int i = 0; i < 9; i++) bus_access(1'b1, 2'd0, 2'd2, 32'h100 + 32'(i), rd);
    check("ovf_irq", 32'(irq), 32'd1);
    bus_access(1'b0, 2'd1, 2'd2, 32'h0, rd);
    check("ovf_status", rd, 32'h0000_0815);
    bus_access(1'b0, 2'd1, 2'd2, 32'h0, rd);
    check("ovf_cleared", rd, 32'h0000_0805);
    check("ovf_irq_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d", i), dev_tx_data, 32'h100 + 32'(i));
      dev_tx_ready = 1'b1;
    end
    @(negedge clk);
    dev_tx_ready = 1'b0;
    check("drain_empty", 32'(dev_tx_valid), 32'd0);

    // RX underflow, then a device word
    bus_access(1'b0, 2'd0, 2'd2, 32'h0, rd);
    check("unf_rdata", rd, 32'h0);
    check("unf_irq", 32'(irq), 32'd1);
    @(negedge clk);
    dev_rx_valid = 1'b1; dev_rx_data = 32'hCAFE_0001;
    @(negedge clk);
    dev_rx_valid = 1'b0;
    bus_access(1'b0, 2'd0, 2'd2, 32'h0, rd);
    check("rx_word", rd, 32'hCAFE_0001);
    bus_access(1'b0, 2'd1, 2'd2, 32'h0, rd);
    check("unf_status", rd, 32'h0000_0026);
    check("rx_irq_clr", 32'(irq), 32'd0);

    // Fill RX, ninth push is refused by dev_rx_ready
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      dev_rx_valid = 1'b1; dev_rx_data = 32'h200 + 32'(i);
    end
    @(negedge clk);
    dev_rx_valid = 1'b0;
    check("rx_full_ready", 32'(dev_rx_ready), 32'd0);
    bus_access(1'b0, 2'd1, 2'd2, 32'h0, rd);
    check("rx_full_status", rd, 32'h0008_000A);
    for (int i = 0; i < 8; i++) begin
      bus_access(1'b0, 2'd0, 2'd2, 32'h0, rd);
      check($sformatf("rx_pop%0d", i), rd, 32'h200 + 32'(i));
    end
    bus_access(1'b0, 2'd1, 2'd2, 32'h0, rd);
    check("rx_empty_status", rd, 32'h0000_0006);

    // en held for 10 cycles: one ready, one push
    @(negedge clk);
    en = 1'b1; rd_wr = 1'b1; addr = 32'h0; wr_size = 2'd2; tb_oe = 1'b1; tb_data = 32'h0000_0077;
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready) rcnt++;
    end
    @(negedge clk);
    en = 1'b0; tb_oe = 1'b0;
    check("held_ready_cnt", 32'(rcnt), 32'd1);
    bus_access(1'b0, 2'd1, 2'd2, 32'h0, rd);
    check("held_tx_count", rd, 32'h0000_0104);
    @(negedge clk);
    check("held_tx_data", dev_tx_data, 32'h0000_0077);
    dev_tx_ready = 1'b1;
    @(negedge clk);
    dev_tx_ready = 1'b0;

    // Abort during WAIT: DATA and SCRATCH writes with no effect
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      en = 1'b1; rd_wr = 1'b1; addr = (k == 0) ? 32'h0 : 32'h8; tb_oe = 1'b1; tb_data = 32'h0000_0088;
      @(negedge clk);
      en = 1'b0; tb_oe = 1'b0;
      rcnt = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (ready) rcnt++;
      end
      check($sformatf("abort%0d_ready", k), 32'(rcnt), 32'd0);
    end
    check("abort_tx_valid", 32'(dev_tx_valid), 32'd0);
    bus_access(1'b0, 2'd2, 2'd2, 32'h0, rd);
    check("abort_scratch", rd, 32'hDEAD_BEEF);

    // Reset asserted mid-WAIT of a SCRATCH read
    bus_access(1'b1, 2'd0, 2'd2, 32'h0000_0099, rd);
    @(negedge clk);
    en = 1'b1; rd_wr = 1'b0; addr = 32'h8;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_bus", 32'(bus_released()), 32'd1);
    check("mid_rst_tx_valid", 32'(dev_tx_valid), 32'd0);
    check("mid_rst_rx_ready", 32'(dev_rx_ready), 32'd1);
    check("mid_rst_irq", 32'(irq), 32'd0);
    rcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready) rcnt++;
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_no_ready", 32'(rcnt), 32'd0);
    bus_access(1'b0, 2'd2, 2'd2, 32'h0, rd);
    check("mid_rst_scratch", rd, 32'h0);
    bus_access(1'b0, 2'd1, 2'd2, 32'h0, rd);
    check("mid_rst_status", rd, 32'h0000_0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
